ccff_chain_loader: RTL and testbench



---
 rtl/ccff_loader_pkg.sv | 20 ++
 rtl/ccff_crc16_serial.sv | 23 ++
 rtl/ccff_chain_loader.sv | 161 ++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader.
//   ccff_ld_state_t : loader FSM states
//   CRC16_POLY/INIT : CRC-16-CCITT constants (MSB-first, no reflection, no xorout)
//   crc16_bit()     : one serial CRC step
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ccff_ld_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b);
    crc16_bit = {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Serial CRC-16-CCITT accumulator, one bit per enabled cycle.
//   clk, rst_n : clock, synchronous active-low reset (to CRC16_INIT)
//   clr        : reload CRC16_INIT (wins over en)
//   en, din    : fold din into the running CRC
//   crc        : current signature
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst_n)   crc <= CRC16_INIT;
    else if (clr) crc <= CRC16_INIT;
    else if (en)  crc <= crc16_bit(crc, din);
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words onto a CCFF configuration chain.
//   prog_clk, pReset           : clock, synchronous active-low reset
//   start                      : begin a load (honoured only in IDLE)
//   cfg_data/cfg_valid/ready   : word stream, MSB shifted first
//   ccff_head, chain_shift_en  : registered serial bit + chain clock-gate enable
//   ccff_tail                  : chain output, sampled in every shift cycle
//   busy, done                 : RUN state, one-cycle DONE pulse
//   bit_count                  : shifts issued in this load
//   crc_in, crc_out            : CRC-16 of head bits / of tail bits
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [15:0]       crc_in,
  output logic [15:0]       crc_out
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WB_W   = $clog2(WORD_W + 1);
  localparam int WA_W   = $clog2(NWORDS + 1);

  localparam logic [WB_W-1:0]  WORD_CNT  = WB_W'(WORD_W);
  localparam logic [WB_W-1:0]  WB_ONE    = WB_W'(1);
  localparam logic [WA_W-1:0]  NW_CNT    = WA_W'(NWORDS);
  localparam logic [WA_W-1:0]  WA_ONE    = WA_W'(1);
  localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  ccff_ld_state_t    state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WB_W-1:0]   wbits_q, wbits_d;     // bits still unsent in shreg
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [WA_W-1:0]   wacc_q, wacc_d;       // words accepted this load
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic              en_q, en_d;
  logic              head_q, head_d;

  logic shift, hs, start_go;

  // en_q is precomputed one edge early, so it equals "this is a shift cycle"
  // for the current register contents while still being a clean flop output.
  assign shift     = en_q;
  assign start_go  = (state_q == IDLE) && start;
  assign cfg_ready = (state_q == RUN) && !hold_vld_q && (wacc_q != NW_CNT);
  assign hs        = cfg_valid && cfg_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    wbits_d     = wbits_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    wacc_d      = wacc_q;
    bit_count_d = bit_count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          bit_count_d = '0;
          wbits_d     = '0;
          hold_vld_d  = 1'b0;
          wacc_d      = '0;
        end
      end
      RUN: begin
        if (shift) begin
          shreg_d     = shreg_q << 1;
          wbits_d     = wbits_q - WB_ONE;
          bit_count_d = bit_count_q + CNT_ONE;
          if (bit_count_q == LAST_CNT) state_d = DONE;
        end
        if (hs) wacc_d = wacc_q + WA_ONE;
        // Refill shreg the moment it runs dry so streaming has no bubble;
        // hold is older than any word arriving this cycle (ready needs hold empty).
        if (wbits_d == '0) begin
          if (hold_vld_q) begin
            shreg_d    = hold_q;
            wbits_d    = WORD_CNT;
            hold_vld_d = 1'b0;
          end else if (hs) begin
            shreg_d = cfg_data;
            wbits_d = WORD_CNT;
          end
        end else if (hs) begin
          hold_d     = cfg_data;
          hold_vld_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    en_d   = (state_d == RUN) && (wbits_d != '0) && (bit_count_d != CHAIN_CNT);
    head_d = en_d && shreg_d[WORD_W-1];
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      wbits_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      wacc_q      <= '0;
      bit_count_q <= '0;
      en_q        <= 1'b0;
      head_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      wbits_q     <= wbits_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      wacc_q      <= wacc_d;
      bit_count_q <= bit_count_d;
      en_q        <= en_d;
      head_q      <= head_d;
    end
  end

  ccff_crc16_serial u_crc_head (
    .clk   (prog_clk),
    .rst_n (pReset),
    .clr   (start_go),
    .en    (en_q),
    .din   (head_q),
    .crc   (crc_in)
  );

  ccff_crc16_serial u_crc_tail (
    .clk   (prog_clk),
    .rst_n (pReset),
    .clr   (start_go),
    .en    (en_q),
    .din   (ccff_tail),
    .crc   (crc_out)
  );

  assign ccff_head      = head_q;
  assign chain_shift_en = en_q;
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign bit_count      = bit_count_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 20-bit (8-bit word) instance with a chain
// model on head/tail, and a 1-bit chain instance for the degenerate case.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic        pReset = 1'b0;
  logic        start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic        cfg_ready, ccff_head, ccff_tail, chain_shift_en, busy, done;
  logic [4:0]  bit_count;
  logic [15:0] crc_in, crc_out;

  logic        s_start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, s_head, s_tail, s_en, s_busy, s_done;
  logic [0:0]  s_bc;
  logic [15:0] s_crc_in, s_crc_out;

  // chain models: shift on the edge ending an enabled cycle
  logic [19:0] chain;
  logic        s_chain;
  logic        chain_ld = 1'b0;
  logic [19:0] chain_ld_val = '0;

  always @(posedge clk) begin
    if (chain_ld)            chain <= chain_ld_val;
    else if (chain_shift_en) chain <= {chain[18:0], ccff_head};
    if (chain_ld)            s_chain <= chain_ld_val[0];
    else if (s_en)           s_chain <= s_head;
  end
  assign ccff_tail = chain[19];
  assign s_tail    = s_chain;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
    .prog_clk(clk), .pReset(pReset), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .chain_shift_en(chain_shift_en), .busy(busy),
    .done(done), .bit_count(bit_count), .crc_in(crc_in), .crc_out(crc_out)
  );

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(1)) dut1 (
    .prog_clk(clk), .pReset(pReset), .start(s_start), .cfg_data(s_data),
    .cfg_valid(s_valid), .cfg_ready(s_ready), .ccff_head(s_head),
    .ccff_tail(s_tail), .chain_shift_en(s_en), .busy(s_busy),
    .done(s_done), .bit_count(s_bc), .crc_in(s_crc_in), .crc_out(s_crc_out)
  );

  // ---------------- reference model ----------------
  // CRC-16-CCITT as polynomial division of the bit sequence v[n-1]..v[0]
  function automatic logic [15:0] crc_of(input logic [19:0] v, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[15] ^ v[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // The first 20 bits of the word stream, first bit at [19]; after a full
  // load the chain holds exactly this vector (first bit nearest the tail).
  function automatic logic [19:0] head_bits(input logic [7:0] w0, w1, w2);
    logic [23:0] s;
    s = {w0, w1, w2};
    return s[23:4];
  endfunction

  // ---------------- load driver / observer ----------------
  logic [19:0] obs_hv, snap;
  int n_shift, n_hs, n_done, first_hs, first_shift, last_shift, done_at, n_stall;
  logic [4:0]  done_bc, end_bc;
  logic [15:0] done_ci, done_co, end_ci, end_co;
  logic        end_busy;

  // gap_mode: 0 valid held high, 1 random valid, 2 12-cycle gap after word 1
  task automatic run_load(input logic [7:0] w0, w1, w2, input int gap_mode,
                          input int rst_bit, input bit poke_run, input bit poke_done);
    logic [7:0] w [3];
    int idx, gap;
    w[0] = w0; w[1] = w1; w[2] = w2;
    obs_hv = '0; n_shift = 0; n_hs = 0; n_done = 0; n_stall = 0;
    first_hs = -1; first_shift = -1; last_shift = -1; done_at = -100;
    idx = 0; gap = 0;
    @(negedge clk);
    snap = chain;
    start = 1'b1; cfg_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (gap > 0) begin
        cfg_valid = 1'b0; gap--;
      end else if (gap_mode == 1) begin
        cfg_valid = ($urandom_range(0, 2) != 0);
      end else begin
        cfg_valid = 1'b1;
      end
      cfg_data = (idx < 3) ? w[idx] : 8'($urandom);
      start = (poke_run && c == 6) || (poke_done && done);
      if (cfg_valid && cfg_ready) begin
        n_hs++;
        if (n_hs == 1) first_hs = c;
        idx++;
        if (gap_mode == 2 && n_hs == 1) gap = 12;
      end
      if (chain_shift_en) begin
        obs_hv = {obs_hv[18:0], ccff_head};
        n_shift++;
        if (first_shift < 0) first_shift = c;
        last_shift = c;
      end else if (busy && n_shift > 0) begin
        n_stall++;
      end
      if (done) begin
        n_done++; done_at = c;
        done_bc = bit_count; done_ci = crc_in; done_co = crc_out;
      end
      if (rst_bit >= 0 && chain_shift_en && int'(bit_count) == rst_bit) begin
        pReset = 1'b0; cfg_valid = 1'b0; start = 1'b0;
        break;
      end
      if (n_done > 0 && c >= done_at + 4) break;
      @(negedge clk);
    end
    start = 1'b0; cfg_valid = 1'b0;
    end_bc = bit_count; end_ci = crc_in; end_co = crc_out; end_busy = busy;
    if (rst_bit < 0 && n_done == 0) begin
      nvec++; nerr++;
      $display("FAIL load_timeout: no done seen within cycle budget (shifts=%0d)", n_shift);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    pReset = 1'b0;
    chain_ld = 1'b1; chain_ld_val = 20'($urandom);
    repeat (3) @(negedge clk);
    chain_ld = 1'b0;
    nvec++; if (cfg_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b want 0", cfg_ready); end
    nvec++; if (ccff_head !== 1'b0 || chain_shift_en !== 1'b0) begin nerr++; $display("FAIL rst_head_en: got %b%b want 00", ccff_head, chain_shift_en); end
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    nvec++; if (bit_count !== 5'd0) begin nerr++; $display("FAIL rst_bit_count: got %0d want 0", bit_count); end
    nvec++; if (crc_in !== 16'hFFFF || crc_out !== 16'hFFFF) begin nerr++; $display("FAIL rst_crc: got %h/%h want ffff/ffff", crc_in, crc_out); end
    pReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1, w2;
    logic [19:0] exp;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin w0 = 8'hA5; w1 = 8'h3C; w2 = 8'hF0; end
      else begin w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom); end
      run_load(w0, w1, w2, 0, -1, 1'b0, 1'b0);
      exp = head_bits(w0, w1, w2);
      if (it == 0) begin
        nvec++; if (obs_hv !== 20'hA53CF) begin nerr++; $display("FAIL b2b_fixed_head: got %h want a53cf", obs_hv); end
      end
      nvec++; if (n_shift !== 20 || obs_hv !== exp) begin nerr++; $display("FAIL b2b_head: got %0d bits %h want 20 bits %h", n_shift, obs_hv, exp); end
      nvec++; if (last_shift - first_shift !== 19 || first_shift - first_hs !== 1) begin nerr++; $display("FAIL b2b_timing: span %0d lat %0d want 19/1", last_shift - first_shift, first_shift - first_hs); end
      nvec++; if (done_at !== last_shift + 1 || n_done !== 1) begin nerr++; $display("FAIL b2b_done: at %0d (n=%0d) want %0d (n=1)", done_at, n_done, last_shift + 1); end
      nvec++; if (n_hs !== 3) begin nerr++; $display("FAIL b2b_words: got %0d want 3", n_hs); end
      nvec++; if (done_bc !== 5'd20 || end_bc !== 5'd20) begin nerr++; $display("FAIL b2b_bit_count: got %0d/%0d want 20", done_bc, end_bc); end
      nvec++; if (done_ci !== crc_of(exp, 20) || end_ci !== done_ci) begin nerr++; $display("FAIL b2b_crc_in: got %h/%h want %h", done_ci, end_ci, crc_of(exp, 20)); end
      nvec++; if (done_co !== crc_of(snap, 20) || end_co !== done_co) begin nerr++; $display("FAIL b2b_crc_out: got %h/%h want %h", done_co, end_co, crc_of(snap, 20)); end
      nvec++; if (chain !== exp) begin nerr++; $display("FAIL b2b_chain: got %h want %h", chain, exp); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] w0, w1, w2;
    logic [19:0] exp;
    for (int it = 0; it < 4; it++) begin
      w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
      run_load(w0, w1, w2, (it == 0) ? 2 : 1, -1, 1'b0, 1'b0);
      exp = head_bits(w0, w1, w2);
      if (it == 0) begin
        nvec++; if (n_stall < 1) begin nerr++; $display("FAIL stall_seen: got %0d stall cycles want >0", n_stall); end
      end
      nvec++; if (n_shift !== 20 || obs_hv !== exp) begin nerr++; $display("FAIL stall_head: got %0d bits %h want 20 bits %h", n_shift, obs_hv, exp); end
      nvec++; if (chain !== exp) begin nerr++; $display("FAIL stall_chain: got %h want %h", chain, exp); end
      nvec++; if (done_bc !== 5'd20 || done_ci !== crc_of(exp, 20)) begin nerr++; $display("FAIL stall_final: got %0d %h want 20 %h", done_bc, done_ci, crc_of(exp, 20)); end
      nvec++; if (done_at !== last_shift + 1) begin nerr++; $display("FAIL stall_done: at %0d want %0d", done_at, last_shift + 1); end
    end
  endtask

  task automatic test_crc_readback();
    logic [7:0] w0, w1, w2;
    logic [15:0] ci1, co1;
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    @(negedge clk); chain_ld = 1'b1; chain_ld_val = 20'hFFFFF;
    @(negedge clk); chain_ld = 1'b0;
    run_load(w0, w1, w2, 0, -1, 1'b0, 1'b0);
    ci1 = done_ci; co1 = done_co;
    nvec++; if (co1 !== crc_of(20'hFFFFF, 20)) begin nerr++; $display("FAIL rb_ones: got %h want %h", co1, crc_of(20'hFFFFF, 20)); end
    run_load(w0, w1, w2, 1, -1, 1'b0, 1'b0);
    nvec++; if (done_co !== ci1) begin nerr++; $display("FAIL rb_second_out: got %h want %h", done_co, ci1); end
    nvec++; if (done_ci !== ci1) begin nerr++; $display("FAIL rb_second_in: got %h want %h", done_ci, ci1); end
  endtask

  task automatic test_reset_midload();
    logic [7:0] w0, w1, w2;
    logic [19:0] exp;
    run_load(8'($urandom), 8'($urandom), 8'($urandom), 0, 7, 1'b0, 1'b0);
    @(negedge clk);
    nvec++; if (busy !== 1'b0 || chain_shift_en !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL mid_rst_ctl: busy/en/done %b%b%b want 000", busy, chain_shift_en, done); end
    nvec++; if (crc_in !== 16'hFFFF || crc_out !== 16'hFFFF || bit_count !== 5'd0) begin nerr++; $display("FAIL mid_rst_state: crc %h/%h cnt %0d want ffff/ffff 0", crc_in, crc_out, bit_count); end
    nvec++; if (cfg_ready !== 1'b0) begin nerr++; $display("FAIL mid_rst_ready: got %b want 0", cfg_ready); end
    pReset = 1'b1;
    @(negedge clk);
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    run_load(w0, w1, w2, 0, -1, 1'b0, 1'b0);
    exp = head_bits(w0, w1, w2);
    nvec++; if (n_shift !== 20 || obs_hv !== exp || done_bc !== 5'd20) begin nerr++; $display("FAIL mid_rst_reload: %0d bits %h cnt %0d want 20 %h 20", n_shift, obs_hv, done_bc, exp); end
    nvec++; if (done_co !== crc_of(snap, 20)) begin nerr++; $display("FAIL mid_rst_crc_out: got %h want %h", done_co, crc_of(snap, 20)); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] w0, w1, w2;
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    run_load(w0, w1, w2, 0, -1, 1'b1, 1'b1);
    nvec++; if (n_done !== 1 || n_shift !== 20) begin nerr++; $display("FAIL start_ign_count: done %0d shifts %0d want 1/20", n_done, n_shift); end
    nvec++; if (done_bc !== 5'd20 || end_bc !== 5'd20) begin nerr++; $display("FAIL start_ign_cnt: got %0d/%0d want 20", done_bc, end_bc); end
    nvec++; if (end_busy !== 1'b0) begin nerr++; $display("FAIL start_ign_idle: busy %b want 0", end_busy); end
    nvec++; if (obs_hv !== head_bits(w0, w1, w2)) begin nerr++; $display("FAIL start_ign_head: got %h want %h", obs_hv, head_bits(w0, w1, w2)); end
  endtask

  task automatic test_single_bit();
    logic [7:0] w;
    logic old;
    int nsh, nhs, nd, sh_at, d_at, late_ready, hbit;
    logic [0:0] bc_d;
    logic [15:0] ci_d, co_d;
    for (int it = 0; it < 3; it++) begin
      w = (it == 0) ? 8'h80 : 8'($urandom);
      nsh = 0; nhs = 0; nd = 0; sh_at = -1; d_at = -1; late_ready = 0; hbit = -1;
      @(negedge clk);
      old = s_chain;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        s_valid = 1'b1; s_data = (nhs == 0) ? w : 8'($urandom);
        if (s_ready && nhs > 0) late_ready++;
        if (s_valid && s_ready) nhs++;
        if (s_en) begin nsh++; sh_at = c; hbit = int'(s_head); end
        if (s_done) begin nd++; d_at = c; bc_d = s_bc; ci_d = s_crc_in; co_d = s_crc_out; end
        if (nd > 0 && c >= d_at + 3) break;
        @(negedge clk);
      end
      s_valid = 1'b0;
      nvec++; if (nd !== 1) begin nerr++; $display("FAIL one_done: got %0d pulses want 1", nd); end
      nvec++; if (nsh !== 1 || hbit !== int'(w[7])) begin nerr++; $display("FAIL one_shift: %0d shifts head %0d want 1 shift head %0d", nsh, hbit, w[7]); end
      nvec++; if (d_at !== sh_at + 1) begin nerr++; $display("FAIL one_done_at: %0d want %0d", d_at, sh_at + 1); end
      nvec++; if (nhs !== 1 || late_ready !== 0) begin nerr++; $display("FAIL one_ready: words %0d late ready %0d want 1/0", nhs, late_ready); end
      nvec++; if (bc_d !== 1'b1 || ci_d !== crc_of({19'd0, w[7]}, 1) || co_d !== crc_of({19'd0, old}, 1)) begin
        nerr++; $display("FAIL one_final: cnt %0d crc %h/%h want 1 %h/%h", bc_d, ci_d, co_d, crc_of({19'd0, w[7]}, 1), crc_of({19'd0, old}, 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_crc_readback();
    test_reset_midload();
    test_start_ignored();
    test_single_bit();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
